// File: rtl/wm_pkg.sv
// Shared types and constants for the washing-machine panel front end.
// Holds the key channel state encoding and default timing values.
package wm_pkg;

    typedef enum logic [1:0] {
        REL = 2'd0,
        PW  = 2'd1,
        PRS = 2'd2,
        RW  = 2'd3
    } ch_state_t;

    localparam int DB_CYCLES_DEFAULT = 400000;
    localparam int CLK_HZ            = 20000000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, qualification counter and FSM.
// Ports: CLK, RST (async, active-high), key_raw (active-low, async),
//        clean (debounced active-low level), press (one-cycle strobe).
import wm_pkg::*;

module key_debounce_ch #(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 19
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_raw,
    output logic clean,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             sync;
    ch_state_t        state_q;
    ch_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             press_q;
    logic             press_d;

    // Flops preset to 1 so a held key after reset looks like a new press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_raw};
        end
    end

    assign sync = sync_q[1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= REL;
            cnt_q   <= '0;
            clean_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            press_q <= press_d;
        end
    end

    // Counting starts at 1 on the first mismatching sample, so reaching
    // CNT_MAX on the next mismatching sample means DB_CYCLES in a row.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        press_d = 1'b0;
        unique case (state_q)
            REL: begin
                if (!sync) begin
                    state_d = PW;
                    cnt_d   = CNT_ONE;
                end
            end
            PW: begin
                if (sync) begin
                    state_d = REL;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRS;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRS: begin
                if (sync) begin
                    state_d = RW;
                    cnt_d   = CNT_ONE;
                end
            end
            RW: begin
                if (!sync) begin
                    state_d = PRS;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = REL;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = REL;
                cnt_d   = '0;
                clean_d = 1'b1;
            end
        endcase
    end

    assign clean = clean_q;
    assign press = press_q;

endmodule

// File: rtl/key_debounce.sv
// Panel key conditioning: three independent debounce channels plus a
// registered multi-key flag. Ports: CLK, RST, key_{s,w,p}_raw in;
// key_{s,w,p} levels, key_{s,w,p}_press strobes, multi_key out.
import wm_pkg::*;

module key_debounce #(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNT_W     = 19
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_s_raw,
    input  logic key_w_raw,
    input  logic key_p_raw,
    output logic key_s,
    output logic key_w,
    output logic key_p,
    output logic key_s_press,
    output logic key_w_press,
    output logic key_p_press,
    output logic multi_key
);

    logic two_low;
    logic multi_q;

    key_debounce_ch #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_ch_s (
        .CLK    (CLK),
        .RST    (RST),
        .key_raw(key_s_raw),
        .clean  (key_s),
        .press  (key_s_press)
    );

    key_debounce_ch #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_ch_w (
        .CLK    (CLK),
        .RST    (RST),
        .key_raw(key_w_raw),
        .clean  (key_w),
        .press  (key_w_press)
    );

    key_debounce_ch #(
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) u_ch_p (
        .CLK    (CLK),
        .RST    (RST),
        .key_raw(key_p_raw),
        .clean  (key_p),
        .press  (key_p_press)
    );

    // Levels are active-low: any pair both at 0 means two keys held.
    assign two_low = (~key_s & ~key_w) |
                     (~key_s & ~key_p) |
                     (~key_w & ~key_p);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= two_low;
        end
    end

    assign multi_key = multi_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with DB_CYCLES=8.
// Directed scenarios followed by random bouncing against a history model.
module tb_key_debounce;

    localparam int DB = 8;
    localparam int CW = 4;

    logic       CLK;
    logic       RST;
    logic [2:0] raw;
    logic       key_s, key_w, key_p;
    logic       key_s_press, key_w_press, key_p_press;
    logic       multi_key;
    logic [2:0] dut_clean;
    logic [2:0] dut_press;

    key_debounce #(
        .DB_CYCLES(DB),
        .CNT_W    (CW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .key_s_raw  (raw[0]),
        .key_w_raw  (raw[1]),
        .key_p_raw  (raw[2]),
        .key_s      (key_s),
        .key_w      (key_w),
        .key_p      (key_p),
        .key_s_press(key_s_press),
        .key_w_press(key_w_press),
        .key_p_press(key_p_press),
        .multi_key  (multi_key)
    );

    assign dut_clean = {key_p, key_w, key_s};
    assign dut_press = {key_p_press, key_w_press, key_s_press};

    initial CLK = 1'b0;
    always #25 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: delayed raw samples and a window of the last DB
    // synchronised samples per key; a level flips once the window is
    // uniformly the opposite of the current level.
    logic [2:0]    m_p1, m_p2;
    logic [DB-1:0] m_hist [3];
    logic [2:0]    m_clean;
    logic [2:0]    m_press;
    logic          m_multi;

    int pcnt [3];
    int pcyc [3];
    int fcyc [3];
    int rcyc [3];
    int nchg [3];
    int mrise, mfall;
    logic [2:0] prev_c;
    logic       prev_m;
    string nm [3] = '{"s", "w", "p"};

    task automatic chk_b(input string tag, input logic obs,
                         input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs,
                         input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p1    = 3'b111;
        m_p2    = 3'b111;
        m_clean = 3'b111;
        m_press = 3'b000;
        m_multi = 1'b0;
        for (int k = 0; k < 3; k++) m_hist[k] = '1;
    endtask

    task automatic model_edge();
        int   nlow;
        logic s;
        if (RST) begin
            model_reset();
        end else begin
            nlow = 0;
            for (int k = 0; k < 3; k++) if (!m_clean[k]) nlow++;
            m_multi = (nlow >= 2);
            for (int k = 0; k < 3; k++) begin
                s = m_p2[k];
                m_p2[k] = m_p1[k];
                m_p1[k] = raw[k];
                m_hist[k] = {m_hist[k][DB-2:0], s};
                m_press[k] = 1'b0;
                if (m_clean[k] && m_hist[k] == '0) begin
                    m_clean[k] = 1'b0;
                    m_press[k] = 1'b1;
                end else if (!m_clean[k] && m_hist[k] == '1) begin
                    m_clean[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic clr_obs();
        for (int k = 0; k < 3; k++) begin
            pcnt[k] = 0;
            pcyc[k] = -1;
            fcyc[k] = -1;
            rcyc[k] = -1;
            nchg[k] = 0;
        end
        mrise = -1;
        mfall = -1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk_b({"level_", nm[k]}, dut_clean[k], m_clean[k]);
            chk_b({"press_", nm[k]}, dut_press[k], m_press[k]);
        end
        chk_b("multi_key", multi_key, m_multi);
        for (int k = 0; k < 3; k++) begin
            if (dut_press[k] === 1'b1) begin
                pcnt[k]++;
                pcyc[k] = cyc;
            end
            if (dut_clean[k] !== prev_c[k]) begin
                nchg[k]++;
                if (dut_clean[k] === 1'b0) fcyc[k] = cyc;
                else rcyc[k] = cyc;
            end
        end
        if (multi_key !== prev_m) begin
            if (multi_key === 1'b1) mrise = cyc;
            else mfall = cyc;
        end
        prev_c = dut_clean;
        prev_m = multi_key;
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        check_all();
    endtask

    int e0;
    int len [3];

    initial begin
        prev_c = 3'b111;
        prev_m = 1'b0;
        clr_obs();
        model_reset();
        raw = 3'b111;
        RST = 1'b1;
        repeat (3) step();
        chk_b("reset_key_s", key_s, 1'b1);
        chk_b("reset_multi", multi_key, 1'b0);

        // Idle after reset
        RST = 1'b0;
        repeat (50) step();
        chk_i("idle_no_press", pcnt[0] + pcnt[1] + pcnt[2], 0);

        // Single clean press of start, held
        clr_obs();
        e0 = cyc + 1;
        raw[0] = 1'b0;
        repeat (110) step();
        chk_i("s_press_count", pcnt[0], 1);
        chk_i("s_press_lat", pcyc[0] - e0, DB + 1);
        chk_i("s_level_lat", fcyc[0] - e0, DB + 1);
        raw[0] = 1'b1;
        repeat (20) step();

        // Water bounce: 5 low, 1 high, 20 low
        clr_obs();
        raw[1] = 1'b0;
        repeat (5) step();
        raw[1] = 1'b1;
        step();
        e0 = cyc + 1;
        raw[1] = 1'b0;
        repeat (20) step();
        chk_i("w_press_count", pcnt[1], 1);
        chk_i("w_press_lat", pcyc[1] - e0, DB + 1);
        chk_i("w_level_changes", nchg[1], 1);
        raw[1] = 1'b1;
        repeat (20) step();

        // Start then pause 3 cycles later, both held, then released
        clr_obs();
        raw[0] = 1'b0;
        repeat (3) step();
        raw[2] = 1'b0;
        repeat (20) step();
        chk_i("sp_strobe_gap", pcyc[2] - pcyc[0], 3);
        chk_i("multi_rise", mrise - fcyc[2], 1);
        raw[0] = 1'b1;
        raw[2] = 1'b1;
        repeat (20) step();
        chk_i("multi_fall", mfall - rcyc[2], 1);
        chk_b("multi_after_rel", multi_key, 1'b0);

        // Pressed start with periodic one-cycle release glitches
        raw[0] = 1'b0;
        repeat (15) step();
        clr_obs();
        for (int i = 0; i < 29; i++) begin
            raw[0] = (i % 6 == 5);
            step();
        end
        chk_i("glitch_no_press", pcnt[0], 0);
        chk_i("glitch_no_change", nchg[0], 0);
        e0 = cyc + 1;
        raw[0] = 1'b1;
        repeat (15) step();
        chk_i("release_lat", rcyc[0] - e0, DB + 1);

        // Reset while pause is qualifying and still held
        clr_obs();
        raw[2] = 1'b0;
        repeat (7) step();
        RST = 1'b1;
        model_reset();
        #1;
        check_all();
        chk_b("rst_key_p", key_p, 1'b1);
        repeat (3) step();
        RST = 1'b0;
        clr_obs();
        e0 = cyc + 1;
        repeat (20) step();
        chk_i("rst_requal_count", pcnt[2], 1);
        chk_i("rst_requal_lat", pcyc[2] - e0, DB + 1);
        raw[2] = 1'b1;
        repeat (20) step();

        // Random bouncing on all keys
        for (int k = 0; k < 3; k++) len[k] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 3; k++) begin
                if (len[k] == 0) begin
                    raw[k] = 1'($urandom_range(0, 1));
                    len[k] = $urandom_range(1, 14);
                end
                len[k]--;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
